// File: rtl/mux_nx1_hs.sv
// mux_nx1_hs: N-to-1 valid/ready channel multiplexer with a registered output stage.
// Channels are picked by explicit select (MODE 0) or by round-robin arbitration (MODE 1).
module mux_nx1_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] In,
  input  logic [N-1:0]       InValid,
  output logic [N-1:0]       InReady,
  input  logic [SELW-1:0]    Sel,
  output logic [WIDTH-1:0]   Out,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [SELW-1:0]    OutSrc
);

  logic [N-1:0]     grant;
  logic             found;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdata;
  logic             space;
  logic             accept;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  src_q, src_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  // Sel only matters in explicit-select mode.
  logic unused_sel;
  assign unused_sel = ^Sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (MODE == 0) begin
      // Out-of-range selects simply match no channel.
      for (int unsigned i = 0; i < N; i++) begin
        if (32'(Sel) == i && InValid[i]) begin
          grant[i] = 1'b1;
        end
      end
    end else begin
      // Two passes give the wrap-around scan ptr..N-1 then 0..ptr-1.
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && i >= 32'(ptr_q) && InValid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && i < 32'(ptr_q) && InValid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = SELW'(i);
        gdata = In[i*WIDTH +: WIDTH];
      end
    end
  end

  assign space   = !valid_q || OutReady;
  assign InReady = reset ? (grant & {N{space}}) : '0;
  assign accept  = |(InValid & InReady);

  always_comb begin
    out_d   = out_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (accept) begin
      out_d   = gdata;
      src_d   = gidx;
      valid_d = 1'b1;
      if (MODE != 0) begin
        ptr_d = (32'(gidx) == N - 1) ? '0 : gidx + SELW'(1);
      end
    end else if (OutReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Out      = out_q;
  assign OutSrc   = src_q;
  assign OutValid = valid_q;

endmodule

// File: tb/tb_mux_nx1_hs.sv
// Self-checking bench for mux_nx1_hs: explicit select (N=4 and N=3) and round-robin (N=4)
// instances, driven by directed tables, hand-written corner sequences and a random scoreboard.
module tb_mux_nx1_hs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Explicit-select instance, N=4.
  logic [127:0] in0;
  logic [3:0]   iv0, ir0;
  logic [1:0]   sel0, src0;
  logic [31:0]  out0;
  logic         ov0, ordy0;

  // Round-robin instance, N=4.
  logic [127:0] in1;
  logic [3:0]   iv1, ir1;
  logic [1:0]   sel1, src1;
  logic [31:0]  out1;
  logic         ov1, ordy1;

  // Explicit-select instance, N=3 (non power of two).
  logic [23:0]  in2;
  logic [2:0]   iv2, ir2;
  logic [1:0]   sel2, src2;
  logic [7:0]   out2;
  logic         ov2, ordy2;

  mux_nx1_hs #(.WIDTH(32), .N(4), .SELW(2), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .In(in0), .InValid(iv0), .InReady(ir0), .Sel(sel0),
    .Out(out0), .OutValid(ov0), .OutReady(ordy0), .OutSrc(src0)
  );

  mux_nx1_hs #(.WIDTH(32), .N(4), .SELW(2), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .In(in1), .InValid(iv1), .InReady(ir1), .Sel(sel1),
    .Out(out1), .OutValid(ov1), .OutReady(ordy1), .OutSrc(src1)
  );

  mux_nx1_hs #(.WIDTH(8), .N(3), .SELW(2), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .In(in2), .InValid(iv2), .InReady(ir2), .Sel(sel2),
    .Out(out2), .OutValid(ov2), .OutReady(ordy2), .OutSrc(src2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [31:0] out;
    logic [1:0]  src;
  } vec0_t;

  typedef struct {
    logic [3:0] iv;
    logic [3:0] ir;
    logic [1:0] src;
  } vecrr_t;

  vec0_t  v0[10];
  vecrr_t vr[10];

  // Stress scoreboard state.
  logic [3:0]  hold, acc;
  logic        pv;
  logic [31:0] pw;
  logic [1:0]  ps;
  int          seqn[4];
  int          waitc[4];
  int          g, mx;
  logic        exp_acc;

  initial begin
    // sel, iv, ordy | inready, ov, out, src after the edge
    v0[0] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    v0[1] = '{2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0};
    v0[2] = '{2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 32'h11111111, 2'd0};
    v0[3] = '{2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 32'h44444444, 2'd3};
    v0[4] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 32'h44444444, 2'd3};
    v0[5] = '{2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h44444444, 2'd3};
    v0[6] = '{2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h44444444, 2'd3};
    v0[7] = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1};
    v0[8] = '{2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h22222222, 2'd1};
    v0[9] = '{2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h22222222, 2'd1};

    // Round-robin from ptr=0 with OutReady held high.
    vr[0] = '{4'b1111, 4'b0001, 2'd0};
    vr[1] = '{4'b1111, 4'b0010, 2'd1};
    vr[2] = '{4'b1111, 4'b0100, 2'd2};
    vr[3] = '{4'b1111, 4'b1000, 2'd3};
    vr[4] = '{4'b1001, 4'b0001, 2'd0};
    vr[5] = '{4'b1001, 4'b1000, 2'd3};
    vr[6] = '{4'b0100, 4'b0100, 2'd2};
    vr[7] = '{4'b0100, 4'b0100, 2'd2};
    vr[8] = '{4'b0110, 4'b0010, 2'd1};
    vr[9] = '{4'b0110, 4'b0100, 2'd2};

    in0 = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    in1 = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    in2 = {8'hA2, 8'hA1, 8'hA0};
    sel1 = 2'd0; iv1 = '0; ordy1 = 1'b1;
    iv2 = '0; sel2 = 2'd0; ordy2 = 1'b1;

    // Reset state, with a grantable request present so InReady gating is visible.
    reset = 1'b0; sel0 = 2'd0; iv0 = 4'b0001; ordy0 = 1'b0;
    #12;
    chk("reset.ov", 64'(ov0), 64'd0);
    chk("reset.out", 64'(out0), 64'd0);
    chk("reset.src", 64'(src0), 64'd0);
    chk("reset.inready", 64'(ir0), 64'd0);
    reset = 1'b1;
    sel0 = 2'd3; iv0 = 4'b1000;
    step();
    chk("reset.first_ov", 64'(ov0), 64'd1);
    chk("reset.first_out", 64'(out0), 64'h44444444);
    chk("reset.first_src", 64'(src0), 64'd3);
    // Async reset mid-cycle while a word is pending.
    #2 reset = 1'b0;
    #1;
    chk("reset.async_ov", 64'(ov0), 64'd0);
    chk("reset.async_out", 64'(out0), 64'd0);
    chk("reset.async_src", 64'(src0), 64'd0);
    chk("reset.async_inready", 64'(ir0), 64'd0);
    #1 reset = 1'b1;
    sel0 = 2'd2; iv0 = 4'b0100; ordy0 = 1'b1;
    step();
    chk("reset.after_out", 64'(out0), 64'hDEADBEEF);
    chk("reset.after_ov", 64'(ov0), 64'd1);
    iv0 = '0;
    step();

    // Explicit select table, including a 3-cycle stall.
    for (int k = 0; k < 10; k++) begin
      sel0 = v0[k].sel; iv0 = v0[k].iv; ordy0 = v0[k].ordy;
      in0[31:0] = (k >= 4 && k <= 6) ? 32'h99990000 + 32'(k) : 32'h11111111;
      #1;
      chk($sformatf("m0[%0d].inready", k), 64'(ir0), 64'(v0[k].ir));
      step();
      chk($sformatf("m0[%0d].ov", k), 64'(ov0), 64'(v0[k].ov));
      chk($sformatf("m0[%0d].out", k), 64'(out0), 64'(v0[k].out));
      chk($sformatf("m0[%0d].src", k), 64'(src0), 64'(v0[k].src));
    end

    // Round-robin table.
    ordy1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      iv1 = vr[k].iv;
      #1;
      chk($sformatf("rr[%0d].inready", k), 64'(ir1), 64'(vr[k].ir));
      step();
      chk($sformatf("rr[%0d].src", k), 64'(src1), 64'(vr[k].src));
      chk($sformatf("rr[%0d].out", k), 64'(out1), 64'(32'hC0DE0000 + 32'(vr[k].src)));
      chk($sformatf("rr[%0d].ov", k), 64'(ov1), 64'd1);
    end

    // Out-of-range select on the N=3 instance.
    sel2 = 2'd1; iv2 = 3'b111; ordy2 = 1'b1;
    #1 chk("bad.good_inready", 64'(ir2), 64'b010);
    step();
    chk("bad.good_out", 64'(out2), 64'hA1);
    sel2 = 2'd3;
    #1 chk("bad.inready", 64'(ir2), 64'd0);
    step();
    chk("bad.ov_drain", 64'(ov2), 64'd0);
    chk("bad.out_hold", 64'(out2), 64'hA1);
    chk("bad.src_hold", 64'(src2), 64'd1);
    ordy2 = 1'b0;
    step();
    chk("bad.ov_stays", 64'(ov2), 64'd0);

    // Random stress on the round-robin instance.
    iv1 = '0; ordy1 = 1'b1;
    step();
    pv = 1'b0; hold = '0;
    for (int i = 0; i < 4; i++) begin
      seqn[i] = 0;
      waitc[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        in1[i*32 +: 32] = {4'(i), 28'(seqn[i])};
        iv1[i] = hold[i] | 1'($urandom_range(0, 1));
      end
      ordy1 = ($urandom_range(0, 3) != 0);
      #1;
      chk("stress.ov", 64'(ov1), 64'(pv));
      if (pv && ordy1) begin
        chk("stress.out", 64'(out1), 64'(pw));
        chk("stress.src", 64'(src1), 64'(ps));
      end
      acc = iv1 & ir1;
      exp_acc = (iv1 != 0) && (!pv || ordy1);
      chk("stress.accept", 64'(|acc), 64'(exp_acc));
      chk("stress.onehot", 64'($countones(acc) <= 1), 64'd1);
      g = -1;
      for (int i = 0; i < 4; i++) if (acc[i]) g = i;
      if (g >= 0) begin
        pv = 1'b1;
        pw = {4'(g), 28'(seqn[g])};
        ps = 2'(g);
        seqn[g]++;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
          if (i == g) waitc[i] = 0;
          else if (iv1[i]) waitc[i]++;
          if (waitc[i] > mx) mx = waitc[i];
        end
        chk("stress.rr_wait", 64'(mx <= 3), 64'd1);
      end else if (ordy1) begin
        pv = 1'b0;
      end
      hold = iv1 & ~acc;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
